robot_arm_axil_regs: RTL
========================

// Module: robot_arm_axil_regs
// PURPOSE
//  AXI4-Lite slave register file of the robot arm control IP; the responder the AXI VIP master drives.
//  Four 32-bit read/write registers (control + three servo/joint set-points) exposed to arm logic.
//  Accepts AW and W independently in any order, one write and one read outstanding at a time.
//  Raises a one-cycle commit strobe per register so downstream servo logic latches new set-points.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  4   byte address width; ADDR[3:2] selects register, ADDR[1:0] ignored
// PORTS
//  S_AXI_ACLK     in   1    clock
//  S_AXI_ARESETN  in   1    reset, synchronous, active-low
//  S_AXI_AWADDR   in   4    write address
//  S_AXI_AWPROT   in   3    ignored
//  S_AXI_AWVALID  in   1    write address valid
//  S_AXI_AWREADY  out  1    write address ready
//  S_AXI_WDATA    in   32   write data
//  S_AXI_WSTRB    in   4    byte enables
//  S_AXI_WVALID   in   1    write data valid
//  S_AXI_WREADY   out  1    write data ready
//  S_AXI_BRESP    out  2    write response, always 2'b00 OKAY
//  S_AXI_BVALID   out  1    write response valid
//  S_AXI_BREADY   in   1    write response ready
//  S_AXI_ARADDR   in   4    read address
//  S_AXI_ARPROT   in   3    ignored
//  S_AXI_ARVALID  in   1    read address valid
//  S_AXI_ARREADY  out  1    read address ready
//  S_AXI_RDATA    out  32   read data
//  S_AXI_RRESP    out  2    read response, always 2'b00 OKAY
//  S_AXI_RVALID   out  1    read data valid
//  S_AXI_RREADY   in   1    read data ready
//  regs_o         out  128  {reg3,reg2,reg1,reg0}, registered contents
//  reg_wr_o       out  4    one-hot, one-cycle pulse: register i committed
// BEHAVIOUR
//  Reset (ARESETN=0 at clock edge): all regs 0, BVALID/RVALID/reg_wr_o 0, AWREADY/WREADY/ARREADY 1, RDATA 0.
//  Write FSM: W_IDLE, W_ADDR (AW held, waiting W), W_DATA (W held, waiting AW), W_RESP.
//   W_IDLE: AWREADY=WREADY=1. AW&W same cycle -> commit -> W_RESP. AW only -> latch addr, W_ADDR
//     (AWREADY=0). W only -> latch data+strobe, W_DATA (WREADY=0).
//   W_ADDR/W_DATA: on missing handshake -> commit -> W_RESP.
//   Commit: byte lanes with WSTRB=1 updated, others kept; reg_wr_o[ADDR[3:2]] pulses the cycle after
//     commit edge, aligned with BVALID rising and updated regs_o.
//   W_RESP: AWREADY=WREADY=0, BVALID=1 held until BREADY; on BVALID&BREADY -> W_IDLE.
//   WSTRB=0 commit: no data change, reg_wr_o still pulses, OKAY response.
//  Read FSM: R_IDLE (ARREADY=1), R_DATA (ARREADY=0, RVALID=1).
//   ARVALID&ARREADY -> RDATA = reg[ARADDR[3:2]] registered, RVALID next cycle (latency 1).
//   RDATA/RVALID stable until RREADY; on RVALID&RREADY -> R_IDLE; new AR accepted next cycle.
//  Read and write to same register in same cycle: read returns pre-commit value.
//  Read and write channels fully independent; never stall each other.
//  VALID outputs never depend combinationally on READY inputs; no combinational in->out paths.
//  Reset mid-transaction: pending addr/data and response dropped, FSMs to IDLE, regs cleared.
// TESTING
//  Sequential writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads -> RDATA 1,2,3,4, BRESP/RRESP 00.
//  W two cycles before AW (0x8, 0xDEADBEEF) -> single commit, reg2=0xDEADBEEF, reg_wr_o=4'b0100 one cycle.
//  reg1=0xFFFFFFFF then write 0x12345678 WSTRB=4'b0101 -> reg1 reads 0xFF34FF78.
//  BREADY low 5 cycles -> BVALID held, AWREADY/WREADY 0; second AW not accepted until B handshake.
//  RREADY low 3 cycles after read of 0xC -> RDATA/RVALID stable; concurrent write to 0x0 completes meanwhile.
//  ARESETN low one cycle while in W_ADDR with regs nonzero -> all regs 0, BVALID 0, READYs 1 next cycle.

Source files
------------

// File: rtl/robot_arm_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit control/set-point registers to the robot arm logic.
// Writes commit once both AW and W have arrived, in either order; reg_wr_o flags each commit.
module robot_arm_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [3:0]                      reg_wr_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  wstate_e         wstate_q, wstate_d;
  rstate_e         rstate_q, rstate_d;
  logic [1:0]      awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   regs_q [4];
  logic [3:0]      reg_wr_q;
  logic [DW-1:0]   rdata_q;

  logic            commit;
  logic [1:0]      c_idx;
  logic [DW-1:0]   c_data;
  logic [SW-1:0]   c_strb;
  logic [DW-1:0]   merged;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM: state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) wstate_q <= W_IDLE;
    else                wstate_q <= wstate_d;
  end

  // Write FSM: next state and the commit address/data mux
  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    c_idx    = awaddr_q;
    c_data   = wdata_q;
    c_strb   = wstrb_q;
    unique case (wstate_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          commit   = 1'b1;
          c_idx    = S_AXI_AWADDR[3:2];
          c_data   = S_AXI_WDATA;
          c_strb   = S_AXI_WSTRB;
          wstate_d = W_RESP;
        end else if (S_AXI_AWVALID) begin
          wstate_d = W_ADDR;
        end else if (S_AXI_WVALID) begin
          wstate_d = W_DATA;
        end
      end
      W_ADDR: begin
        if (S_AXI_WVALID) begin
          commit   = 1'b1;
          c_data   = S_AXI_WDATA;
          c_strb   = S_AXI_WSTRB;
          wstate_d = W_RESP;
        end
      end
      W_DATA: begin
        if (S_AXI_AWVALID) begin
          commit   = 1'b1;
          c_idx    = S_AXI_AWADDR[3:2];
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM: outputs depend on state only, never on incoming READY/VALID
  always_comb begin
    S_AXI_AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_DATA);
    S_AXI_WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_ADDR);
    S_AXI_BVALID  = (wstate_q == W_RESP);
    S_AXI_BRESP   = '0;
  end

  always_comb begin
    merged = regs_q[c_idx];
    for (int unsigned b = 0; b < SW; b++) begin
      if (c_strb[b]) merged[8*b +: 8] = c_data[8*b +: 8];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      reg_wr_q <= '0;
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      if (wstate_q == W_IDLE && S_AXI_AWVALID && !S_AXI_WVALID) awaddr_q <= S_AXI_AWADDR[3:2];
      if (wstate_q == W_IDLE && S_AXI_WVALID && !S_AXI_AWVALID) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      reg_wr_q <= '0;
      if (commit) begin
        regs_q[c_idx]   <= merged;
        reg_wr_q[c_idx] <= 1'b1;
      end
    end
  end

  // Read FSM: state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) rstate_q <= R_IDLE;
    else                rstate_q <= rstate_d;
  end

  // Read FSM: next state
  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE:  if (S_AXI_ARVALID) rstate_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY)  rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    S_AXI_ARREADY = (rstate_q == R_IDLE);
    S_AXI_RVALID  = (rstate_q == R_DATA);
    S_AXI_RRESP   = '0;
  end

  // Sampled from regs_q, so a same-cycle write to the same register is not yet visible
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN)                          rdata_q <= '0;
    else if (rstate_q == R_IDLE && S_AXI_ARVALID) rdata_q <= regs_q[S_AXI_ARADDR[3:2]];
  end

  assign S_AXI_RDATA = rdata_q;
  assign regs_o      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign reg_wr_o    = reg_wr_q;

endmodule
